// File: rtl/instr_fetch_pkg.sv
// Shared ISA constants and fetch FSM state type for the instruction front end.
package instr_fetch_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_NOP     = 6'b000000;
    localparam logic [OP_W-1:0] OP_ECALL   = 6'b010111;
    localparam logic [OP_W-1:0] OP_JUMP_LO = 6'b001111;
    localparam logic [OP_W-1:0] OP_JUMP_HI = 6'b010011;

    typedef enum logic [2:0] {
        StReq   = 3'd0,
        StWait  = 3'd1,
        StHold  = 3'd2,
        StDrain = 3'd3,
        StHalt  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding memory request, holds the fetched
// word for the decoder, follows PC redirects and halts after an ECALL.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [31:0]       mem_rsp_data_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [OP_W-1:0]   opcode_o,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              resume_i,
    output logic              halted_o
);

    localparam logic [ADDR_W-1:0] AlignMask  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ResetPcAln = RESET_PC & AlignMask;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] target;

    assign target = redirect_pc_i & AlignMask;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            StReq: begin
                // A redirect during the handshake still leaves a response in flight.
                if (redirect_valid_i) begin
                    pc_d    = target;
                    state_d = mem_req_ready_i ? StDrain : StReq;
                end else if (mem_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect_valid_i) begin
                    pc_d    = target;
                    state_d = mem_rsp_valid_i ? StReq : StDrain;
                end else if (mem_rsp_valid_i) begin
                    instr_d = mem_rsp_data_i;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (redirect_valid_i) begin
                    pc_d    = target;
                    state_d = StReq;
                end else if (instr_ready_i) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = (instr_q[31:26] == OP_ECALL) ? StHalt : StReq;
                end
            end
            StDrain: begin
                if (redirect_valid_i) begin
                    pc_d = target;
                end
                if (mem_rsp_valid_i) begin
                    state_d = StReq;
                end
            end
            StHalt: begin
                if (resume_i) begin
                    if (redirect_valid_i) begin
                        pc_d = target;
                    end
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StReq;
            pc_q    <= ResetPcAln;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Request is masked during the reset cycle itself.
    assign mem_req_valid_o = (state_q == StReq) && !rst_i;
    assign mem_addr_o      = pc_q;
    assign instr_valid_o   = (state_q == StHold);
    assign instr_o         = instr_q;
    assign opcode_o        = instr_valid_o ? instr_q[31:26] : OP_NOP;
    assign pc_o            = pc_q;
    assign halted_o        = (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch with a program-flow reference model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resume;
    logic        halted;

    instr_fetch dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_addr_o       (mem_addr),
        .mem_rsp_valid_i  (mem_rsp_valid),
        .mem_rsp_data_i   (mem_rsp_data),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_o          (instr),
        .opcode_o         (opcode),
        .pc_o             (pc),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .resume_i         (resume),
        .halted_o         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          consumes = 0;
    logic [31:0] mem [64];
    logic        pending  = 1'b0;
    logic [31:0] pend_addr = '0;
    int          cnt      = 0;
    int          rsp_lat  = 0;
    logic        ready_knob = 1'b0;
    logic        rand_mode  = 1'b0;
    logic [31:0] exp_pc     = '0;
    logic        exp_halted = 1'b0;
    logic [31:0] req_addrs[$];
    int          req_cycles[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input logic v);
        ready_knob    = v;
        mem_req_ready = v && !pending;
    endtask

    // One clock: memory responder, program-flow model update, per-cycle checks.
    task automatic step();
        logic        req_fire, rsp_fire, consume, redir, res, rst_e, was_valid;
        logic [31:0] was_addr, tgt, w;
        req_fire  = mem_req_valid && mem_req_ready;
        rsp_fire  = mem_rsp_valid;
        consume   = instr_valid && instr_ready;
        redir     = redirect_valid;
        res       = resume;
        rst_e     = rst;
        was_valid = mem_req_valid;
        was_addr  = mem_addr;
        tgt       = redirect_pc & ~32'h3;
        @(posedge clk);
        #1;
        cycle++;
        if (rand_mode) rsp_lat = $urandom_range(0, 3);
        if (rsp_fire) pending = 1'b0;
        else if (pending && cnt > 0) cnt--;
        if (req_fire) begin
            pending   = 1'b1;
            pend_addr = was_addr;
            cnt       = rsp_lat;
            req_addrs.push_back(was_addr);
            req_cycles.push_back(cycle);
        end
        mem_rsp_valid = pending && (cnt == 0);
        mem_rsp_data  = mem_rsp_valid ? word_at(pend_addr) : 32'hDEAD_BEEF;
        mem_req_ready = (rand_mode ? ($urandom_range(0, 99) < 60) : ready_knob) && !pending;

        if (rst_e) begin
            exp_pc     = '0;
            exp_halted = 1'b0;
        end else if (exp_halted) begin
            if (res) begin
                exp_halted = 1'b0;
                if (redir) exp_pc = tgt;
            end
        end else if (redir) begin
            exp_pc = tgt;
        end else if (consume) begin
            w = word_at(exp_pc);
            if (w[31:26] == 6'b010111) exp_halted = 1'b1;
            exp_pc = exp_pc + 32'd4;
        end
        if (consume) consumes++;

        w = word_at(exp_pc);
        check("pc", pc, exp_pc);
        check("halted", 32'(halted), 32'(exp_halted));
        check("opcode", 32'(opcode), instr_valid ? 32'(w[31:26]) : 32'd0);
        if (instr_valid) check("instr", instr, w);
        if (mem_req_valid) check("mem_addr", mem_addr, exp_pc);
        if (exp_halted) check("halt_quiet", 32'({mem_req_valid, instr_valid}), 32'd0);
        if (was_valid && !req_fire && !redir && !rst_e) begin
            check("req_hold_valid", 32'(mem_req_valid), 32'd1);
            check("req_hold_addr", mem_addr, was_addr);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; resume = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0400_0000 | 32'(i);
        mem[2] = 32'h5C00_0000;

        // Reset state
        set_ready(1'b1);
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        rst = 1'b0;
        #1;
        check("req_after_rst", 32'(mem_req_valid), 32'd1);

        // Straight-line fetch of 0x0, 0x4, 0x8
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && req_addrs.size() < 3; i++) begin
            step();
            if (instr_valid) check("t1_opcode", 32'(opcode), 32'h01);
        end
        check("t1_nreq", 32'(req_addrs.size()), 32'd3);
        if (req_addrs.size() >= 3) begin
            check("t1_addr0", req_addrs[0], 32'h0);
            check("t1_addr1", req_addrs[1], 32'h4);
            check("t1_addr2", req_addrs[2], 32'h8);
            check("t1_gap1", 32'(req_cycles[1] - req_cycles[0]), 32'd3);
            check("t1_gap2", 32'(req_cycles[2] - req_cycles[1]), 32'd3);
        end

        // Decoder backpressure on the ECALL word
        instr_ready = 1'b0;
        step();
        check("t2_valid", 32'(instr_valid), 32'd1);
        check("t2_ecall_op", 32'(opcode), 32'h17);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_instr_stable", instr, 32'h5C00_0000);
            check("t2_pc_stable", pc, 32'h8);
        end
        check("t2_no_extra_req", 32'(req_addrs.size()), 32'd3);

        // ECALL halt, ignored lone redirect, resume under memory backpressure
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("t3_halted", 32'(halted), 32'd1);
        check("t3_pc", pc, 32'hC);
        check("t3_no_req", 32'(mem_req_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        step();
        check("t3_redir_ignored", pc, 32'hC);
        check("t3_still_halted", 32'(halted), 32'd1);
        set_ready(1'b0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("t3_resumed", 32'(halted), 32'd0);
        check("t3_req_valid", 32'(mem_req_valid), 32'd1);
        check("t3_req_addr", mem_addr, 32'hC);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_req_held", 32'(mem_req_valid), 32'd1);
            check("t2_addr_held", mem_addr, 32'hC);
        end
        check("t2_no_req_fire", 32'(req_addrs.size()), 32'd3);
        rsp_lat = 2;
        set_ready(1'b1);
        step();
        check("t3_nreq", 32'(req_addrs.size()), 32'd4);
        check("t3_fire_addr", req_addrs[$], 32'hC);

        // Redirect while waiting: stale response dropped
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step();
        redirect_valid = 1'b0;
        check("t4_pc", pc, 32'h100);
        for (int i = 0; i < 8 && !mem_req_valid; i++) begin
            step();
            check("t4_no_instr", 32'(instr_valid), 32'd0);
        end
        check("t4_req_valid", 32'(mem_req_valid), 32'd1);
        check("t4_req_addr", mem_addr, 32'h100);
        rsp_lat = 0;

        // Redirect beats consume in HOLD
        step();
        step();
        check("t5_hold", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h22; instr_ready = 1'b1;
        step();
        redirect_valid = 1'b0; instr_ready = 1'b0;
        check("t5_pc", pc, 32'h20);
        check("t5_dropped", 32'(instr_valid), 32'd0);

        // Reset while holding an instruction
        step();
        step();
        check("t6_hold", 32'(instr_valid), 32'd1);
        rst = 1'b1;
        step();
        check("t6_pc", pc, 32'h0);
        check("t6_valid", 32'(instr_valid), 32'd0);
        check("t6_halted", 32'(halted), 32'd0);
        check("t6_req_masked", 32'(mem_req_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("t6_req_valid", 32'(mem_req_valid), 32'd1);
        check("t6_req_addr", mem_addr, 32'h0);

        // Reset with a response still in flight; late response must be ignored
        rsp_lat = 3;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = req_addrs.size();
        for (int i = 0; i < 10 && req_addrs.size() == n; i++) step();
        check("t6_late_nreq", 32'(req_addrs.size()), 32'(n + 1));
        check("t6_late_addr", req_addrs[$], 32'h0);
        check("t6_late_valid", 32'(instr_valid), 32'd0);
        rsp_lat = 0;

        // Randomized traffic against the program-flow model
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[5]  = 32'h5C00_1234;
        mem[40] = 32'h5C00_0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rand_mode = 1'b1;
        n = consumes;
        for (int i = 0; i < 2000; i++) begin
            instr_ready    = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = 32'($urandom_range(0, 255));
            resume         = ($urandom_range(0, 99) < 30);
            step();
        end
        check("rand_progress", 32'(consumes - n >= 50), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
